// File: rtl/control_pkg.sv
// Shared types for the bus CPU control sequencer: control word layout, opcodes and T-state constants.
package control_pkg;

    localparam int STEP_W = 3;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_in;
        logic ram_out;
        logic ram_in;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic flags_in;
        logic out_in;
        logic halt;
    } ctrl_t;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    // Control word presented for as long as the CPU stays halted.
    localparam ctrl_t CTRL_HALT_ONLY = ctrl_t'(16'h0001);

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (T-state, opcode, flags) -> control word and last-step marker.
module microcode_rom
    import control_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [STEP_W-1:0]   step,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output ctrl_t               ctrl,
    output logic                last_step
);

    opcode_e op;
    assign op = opcode_e'(opcode[3:0]);

    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        case (step)
            T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
            end
            T1: begin
                ctrl.ram_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            T2: begin
                // T2 always runs, even when the opcode leaves it empty.
                last_step = 1'b1;
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.mar_in = 1'b1;
                        last_step   = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.a_in   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.ir_out  = carry_flag;
                        ctrl.pc_load = carry_flag;
                    end
                    OP_JZ: begin
                        ctrl.ir_out  = zero_flag;
                        ctrl.pc_load = zero_flag;
                    end
                    OP_OUT: begin
                        ctrl.a_out  = 1'b1;
                        ctrl.out_in = 1'b1;
                    end
                    OP_HLT: begin
                        ctrl.halt = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            T3: begin
                last_step = 1'b1;
                case (op)
                    OP_LDA: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.a_in    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.b_in    = 1'b1;
                        last_step    = 1'b0;
                    end
                    OP_STA: begin
                        ctrl.a_out  = 1'b1;
                        ctrl.ram_in = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (op == OP_ADD || op == OP_SUB) begin
                    ctrl.alu_out  = 1'b1;
                    ctrl.a_in     = 1'b1;
                    ctrl.flags_in = 1'b1;
                    ctrl.alu_sub  = (op == OP_SUB);
                end
            end
            default: begin
                last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter, sticky halt latch and reset gating around the microcode ROM.
// Build option: CTRL_EARLY_END_EN returns to T0 right after an instruction's last useful step.
module control_sequencer
    import control_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int NUM_STEPS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OPCODE_W-1:0]          opcode,
    input  logic                         carry_flag,
    input  logic                         zero_flag,
    output ctrl_t                        ctrl,
    output logic [$clog2(NUM_STEPS)-1:0] step,
    output logic                         halted
);

    localparam int SW     = $clog2(NUM_STEPS);
    localparam int CTRL_W = $bits(ctrl_t);
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

    logic [SW-1:0] step_reg, step_next;
    logic          halted_reg, halted_next;
    ctrl_t         rom_ctrl;
    logic          rom_last;
    logic          wrap;

    microcode_rom #(
        .OPCODE_W(OPCODE_W)
    ) u_rom (
        .step      (step_reg),
        .opcode    (opcode),
        .carry_flag(carry_flag),
        .zero_flag (zero_flag),
        .ctrl      (rom_ctrl),
        .last_step (rom_last)
    );

`ifdef CTRL_EARLY_END_EN
    assign wrap = rom_last || (step_reg == LAST_STEP);
`else
    logic unused_rom_last;
    assign unused_rom_last = rom_last;
    assign wrap = (step_reg == LAST_STEP);
`endif

    always_comb begin
        step_next   = step_reg;
        halted_next = halted_reg;
        if (!halted_reg) begin
            // HLT T2 latches halt and leaves step parked at T2.
            if (rom_ctrl.halt) begin
                halted_next = 1'b1;
            end else if (wrap) begin
                step_next = '0;
            end else begin
                step_next = step_reg + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_reg   <= '0;
            halted_reg <= 1'b0;
        end else begin
            step_reg   <= step_next;
            halted_reg <= halted_next;
        end
    end

    // Reset masks the control word combinationally so no strobe escapes mid-instruction.
    logic [CTRL_W-1:0] ctrl_raw, ctrl_gated;
    assign ctrl_raw = halted_reg ? CTRL_HALT_ONLY : rom_ctrl;

    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_gate
            assign ctrl_gated[gi] = rst & ctrl_raw[gi];
        end
    endgenerate

    assign ctrl   = ctrl_t'(ctrl_gated);
    assign step   = step_reg;
    assign halted = halted_reg;

endmodule
